cvxif_stream_ctrl: RTL and testbench

- Sequencing stage directly upstream of the custom-instruction blackbox.
- Accepts one custom vector instruction at a time, with fully-captured source vectors.
- Plays each source vector into the blackbox in1/in2 ap_fifo read ports one 64-bit word at a time, and starts the selected kernel with the ap_ctrl_hs protocol.
- Collects the out_r word stream into a result buffer and returns the result to the CV-X-IF result path, with watchdog error reporting.

---
 rtl/cvxif_instr_pkg.sv | 34 +++
 rtl/cvxif_stream_src.sv | 56 +++++
 rtl/cvxif_stream_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_cvxif_stream_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_instr_pkg.sv
// Shared types for the custom vector instruction path.
// Kernel selects, stream sequencer states and per-kernel vector lengths.
package cvxif_instr_pkg;

    typedef enum logic [1:0] {
        OpNone           = 2'd0,
        OpNv12ToCag444   = 2'd1,
        OpCag444ToRgb888 = 2'd2
    } custom_vec_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } stream_state_e;

    // Word counts per kernel, indexed by custom_vec_op_e
    localparam int unsigned CustomVlenIn1 [4] = '{0, 2, 3, 0};
    localparam int unsigned CustomVlenIn2 [4] = '{0, 2, 0, 0};
    localparam int unsigned CustomVlenOut [4] = '{0, 3, 3, 0};

    function automatic int unsigned vlen_in1(input custom_vec_op_e op);
        return CustomVlenIn1[op];
    endfunction

    function automatic int unsigned vlen_in2(input custom_vec_op_e op);
        return CustomVlenIn2[op];
    endfunction

    function automatic int unsigned vlen_out(input custom_vec_op_e op);
        return CustomVlenOut[op];
    endfunction

endpackage

// File: rtl/cvxif_stream_src.sv
// One source vector presented as an ap_fifo read port.
// Holds the captured words and walks a read pointer over them.
module cvxif_stream_src
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned MaxVlen = 4,
    parameter int unsigned CntW    = $clog2(MaxVlen + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     active,
    input  logic [MaxVlen-1:0][63:0] load_data,
    input  logic [CntW-1:0]          load_len,
    input  logic                     read,
    output logic [63:0]              dout,
    output logic                     empty_n
);

    logic [MaxVlen-1:0][63:0] data_q, data_d;
    logic [CntW-1:0]          len_q, len_d;
    logic [CntW-1:0]          rd_q, rd_d;

    always_comb begin
        data_d  = data_q;
        len_d   = len_q;
        rd_d    = rd_q;
        empty_n = active && (rd_q < len_q);
        dout    = '0;
        for (int i = 0; i < MaxVlen; i++) begin
            if (rd_q == CntW'(i)) begin
                dout = data_q[i];
            end
        end
        if (load) begin
            data_d = load_data;
            len_d  = load_len;
            rd_d   = '0;
        end else if (read && empty_n) begin
            rd_d = rd_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            len_q  <= '0;
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: rtl/cvxif_stream_ctrl.sv
// Sequencer in front of the custom-instruction blackbox: streams sources
// in, starts the kernel, collects out_r words and returns the result.
module cvxif_stream_ctrl
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned MaxVlen       = 4,
    parameter int unsigned TimeoutCycles = 4096,
    parameter int unsigned CntW          = $clog2(MaxVlen + 1)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  custom_vec_op_e           issue_opcode,
    input  logic [CntW-1:0]          issue_vlen1,
    input  logic [CntW-1:0]          issue_vlen2,
    input  logic [CntW-1:0]          issue_vlen_out,
    input  logic [MaxVlen-1:0][63:0] issue_src1,
    input  logic [MaxVlen-1:0][63:0] issue_src2,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [MaxVlen-1:0][63:0] result_data,
    output logic [CntW-1:0]          result_count,
    output logic                     result_err,
    output custom_vec_op_e           bb_opcode,
    output logic                     bb_fire,
    output logic                     bb_ap_start,
    input  logic                     bb_ap_done,
    input  logic                     bb_ap_ready,
    output logic [63:0]              bb_in1_dout,
    output logic                     bb_in1_empty_n,
    input  logic                     bb_in1_read,
    output logic [63:0]              bb_in2_dout,
    output logic                     bb_in2_empty_n,
    input  logic                     bb_in2_read,
    input  logic [63:0]              bb_out_r_din,
    output logic                     bb_out_r_full_n,
    input  logic                     bb_out_r_write
);

    localparam int unsigned WdW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [WdW-1:0] WdLast =
        WdW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

    function automatic logic [CntW-1:0] clamp_len(input logic [CntW-1:0] len);
        return (len > CntW'(MaxVlen)) ? CntW'(MaxVlen) : len;
    endfunction

    stream_state_e            state_q, state_d;
    custom_vec_op_e           opcode_q, opcode_d;
    logic [CntW-1:0]          vlen_out_q, vlen_out_d;
    logic [CntW-1:0]          wr_q, wr_d;
    logic [MaxVlen-1:0][63:0] buf_q, buf_d;
    logic                     err_q, err_d;
    logic                     done_seen_q, done_seen_d;
    logic                     start_pending_q, start_pending_d;
    logic [WdW-1:0]           wdog_q, wdog_d;

    logic load;
    logic run;
    logic full_n;
    logic timeout;

    cvxif_stream_src #(
        .MaxVlen(MaxVlen),
        .CntW   (CntW)
    ) u_src1 (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .load     (load),
        .active   (run),
        .load_data(issue_src1),
        .load_len (clamp_len(issue_vlen1)),
        .read     (bb_in1_read),
        .dout     (bb_in1_dout),
        .empty_n  (bb_in1_empty_n)
    );

    cvxif_stream_src #(
        .MaxVlen(MaxVlen),
        .CntW   (CntW)
    ) u_src2 (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .load     (load),
        .active   (run),
        .load_data(issue_src2),
        .load_len (clamp_len(issue_vlen2)),
        .read     (bb_in2_read),
        .dout     (bb_in2_dout),
        .empty_n  (bb_in2_empty_n)
    );

    always_comb begin
        state_d         = state_q;
        opcode_d        = opcode_q;
        vlen_out_d      = vlen_out_q;
        wr_d            = wr_q;
        buf_d           = buf_q;
        err_d           = err_q;
        done_seen_d     = done_seen_q;
        start_pending_d = start_pending_q;
        wdog_d          = wdog_q;

        issue_ready     = 1'b0;
        bb_fire         = 1'b0;
        bb_opcode       = opcode_q;
        bb_ap_start     = 1'b0;
        result_valid    = 1'b0;
        result_data     = '0;
        result_count    = '0;
        result_err      = 1'b0;
        load            = 1'b0;
        run             = 1'b0;
        full_n          = 1'b0;
        timeout         = 1'b0;

        unique case (state_q)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    bb_fire         = 1'b1;
                    bb_opcode       = issue_opcode;
                    load            = 1'b1;
                    opcode_d        = issue_opcode;
                    vlen_out_d      = clamp_len(issue_vlen_out);
                    wr_d            = '0;
                    buf_d           = '0;
                    err_d           = 1'b0;
                    done_seen_d     = 1'b0;
                    start_pending_d = 1'b1;
                    wdog_d          = '0;
                    state_d         = RUN;
                end
            end
            RUN: begin
                run         = 1'b1;
                timeout     = (TimeoutCycles != 0) && (wdog_q == WdLast);
                bb_ap_start = start_pending_q && !timeout;
                full_n      = (wr_q < vlen_out_q);
                wdog_d      = wdog_q + WdW'(1);
                if (bb_ap_ready) begin
                    start_pending_d = 1'b0;
                end
                // Writes past the expected length are dropped but flagged
                if (bb_out_r_write) begin
                    if (full_n) begin
                        for (int i = 0; i < MaxVlen; i++) begin
                            if (wr_q == CntW'(i)) begin
                                buf_d[i] = bb_out_r_din;
                            end
                        end
                        wr_d = wr_q + CntW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (bb_ap_done) begin
                    done_seen_d = 1'b1;
                end
                if ((done_seen_q || bb_ap_done) && (wr_d == vlen_out_q)) begin
                    start_pending_d = 1'b0;
                    state_d         = RESP;
                end else if (timeout) begin
                    start_pending_d = 1'b0;
                    err_d           = 1'b1;
                    state_d         = RESP;
                end
            end
            RESP: begin
                result_valid = 1'b1;
                result_data  = buf_q;
                result_count = wr_q;
                result_err   = err_q;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bb_out_r_full_n = full_n;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q         <= IDLE;
            opcode_q        <= OpNone;
            vlen_out_q      <= '0;
            wr_q            <= '0;
            buf_q           <= '0;
            err_q           <= 1'b0;
            done_seen_q     <= 1'b0;
            start_pending_q <= 1'b0;
            wdog_q          <= '0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            vlen_out_q      <= vlen_out_d;
            wr_q            <= wr_d;
            buf_q           <= buf_d;
            err_q           <= err_d;
            done_seen_q     <= done_seen_d;
            start_pending_q <= start_pending_d;
            wdog_q          <= wdog_d;
        end
    end

endmodule

// File: tb/tb_cvxif_stream_ctrl.sv
// Directed bench for cvxif_stream_ctrl with an inline blackbox model.
// Each task plays one scenario cycle by cycle and checks hand-computed values.
module tb_cvxif_stream_ctrl;
    import cvxif_instr_pkg::*;

    localparam int unsigned MaxVlen = 4;
    localparam int unsigned Tmo     = 16;
    localparam int unsigned CntW    = $clog2(MaxVlen + 1);

    logic                     ap_clk = 1'b0;
    logic                     ap_rst_n;
    logic                     issue_valid;
    logic                     issue_ready;
    custom_vec_op_e           issue_opcode;
    logic [CntW-1:0]          issue_vlen1, issue_vlen2, issue_vlen_out;
    logic [MaxVlen-1:0][63:0] issue_src1, issue_src2;
    logic                     result_valid;
    logic                     result_ready;
    logic [MaxVlen-1:0][63:0] result_data;
    logic [CntW-1:0]          result_count;
    logic                     result_err;
    custom_vec_op_e           bb_opcode;
    logic                     bb_fire, bb_ap_start, bb_ap_done, bb_ap_ready;
    logic [63:0]              bb_in1_dout, bb_in2_dout, bb_out_r_din;
    logic                     bb_in1_empty_n, bb_in1_read;
    logic                     bb_in2_empty_n, bb_in2_read;
    logic                     bb_out_r_full_n, bb_out_r_write;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    cvxif_stream_ctrl #(
        .MaxVlen      (MaxVlen),
        .TimeoutCycles(Tmo)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_opcode   (issue_opcode),
        .issue_vlen1    (issue_vlen1),
        .issue_vlen2    (issue_vlen2),
        .issue_vlen_out (issue_vlen_out),
        .issue_src1     (issue_src1),
        .issue_src2     (issue_src2),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_data    (result_data),
        .result_count   (result_count),
        .result_err     (result_err),
        .bb_opcode      (bb_opcode),
        .bb_fire        (bb_fire),
        .bb_ap_start    (bb_ap_start),
        .bb_ap_done     (bb_ap_done),
        .bb_ap_ready    (bb_ap_ready),
        .bb_in1_dout    (bb_in1_dout),
        .bb_in1_empty_n (bb_in1_empty_n),
        .bb_in1_read    (bb_in1_read),
        .bb_in2_dout    (bb_in2_dout),
        .bb_in2_empty_n (bb_in2_empty_n),
        .bb_in2_read    (bb_in2_read),
        .bb_out_r_din   (bb_out_r_din),
        .bb_out_r_full_n(bb_out_r_full_n),
        .bb_out_r_write (bb_out_r_write)
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic bb_idle();
        bb_ap_done     = 1'b0;
        bb_ap_ready    = 1'b0;
        bb_in1_read    = 1'b0;
        bb_in2_read    = 1'b0;
        bb_out_r_write = 1'b0;
        bb_out_r_din   = '0;
    endtask

    task automatic drive_issue(input custom_vec_op_e op,
                               input logic [CntW-1:0] v1,
                               input logic [CntW-1:0] v2,
                               input logic [CntW-1:0] vo,
                               input logic [MaxVlen-1:0][63:0] s1,
                               input logic [MaxVlen-1:0][63:0] s2);
        issue_valid    = 1'b1;
        issue_opcode   = op;
        issue_vlen1    = v1;
        issue_vlen2    = v2;
        issue_vlen_out = vo;
        issue_src1     = s1;
        issue_src2     = s2;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready got %0b want 1", issue_ready); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_result_valid got %0b want 0", result_valid); end
        checks++; if ({bb_ap_start, bb_fire, bb_in1_empty_n, bb_in2_empty_n, bb_out_r_full_n} !== 5'b0) begin
            errors++; $display("FAIL rst_bb_ctrl got %b want 00000",
                {bb_ap_start, bb_fire, bb_in1_empty_n, bb_in2_empty_n, bb_out_r_full_n}); end
        checks++; if (bb_opcode !== OpNone) begin errors++; $display("FAIL rst_opcode got %0d want 0", bb_opcode); end
        checks++; if (result_data !== '0 || result_count !== '0 || result_err !== 1'b0) begin
            errors++; $display("FAIL rst_result got data=%h cnt=%0d err=%0b want 0", result_data, result_count, result_err); end
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [MaxVlen-1:0][63:0] s1, s2, exp;
        s1 = '0; s1[0] = 64'h1110; s1[1] = 64'h1111;
        s2 = '0; s2[0] = 64'h2220; s2[1] = 64'h2221;
        exp = '0; exp[0] = 64'hA; exp[1] = 64'hB; exp[2] = 64'hC;
        drive_issue(OpNv12ToCag444, 3'd2, 3'd2, 3'd3, s1, s2);
        #1;
        checks++; if (bb_fire !== 1'b1 || bb_opcode !== OpNv12ToCag444) begin
            errors++; $display("FAIL basic_fire got fire=%0b op=%0d want 1/1", bb_fire, bb_opcode); end
        tick();
        issue_valid = 1'b0;
        bb_ap_ready = 1'b1; bb_in1_read = 1'b1; bb_in2_read = 1'b1;
        #1;
        checks++; if (bb_ap_start !== 1'b1 || bb_fire !== 1'b0 || issue_ready !== 1'b0) begin
            errors++; $display("FAIL basic_start got start=%0b fire=%0b rdy=%0b want 1/0/0", bb_ap_start, bb_fire, issue_ready); end
        checks++; if (bb_in1_dout !== s1[0] || bb_in2_dout !== s2[0] || bb_in1_empty_n !== 1'b1) begin
            errors++; $display("FAIL basic_word0 got %h %h want %h %h", bb_in1_dout, bb_in2_dout, s1[0], s2[0]); end
        tick();
        bb_ap_ready = 1'b0;
        #1;
        checks++; if (bb_ap_start !== 1'b0) begin errors++; $display("FAIL basic_start_clr got %0b want 0", bb_ap_start); end
        checks++; if (bb_in1_dout !== s1[1] || bb_in2_dout !== s2[1]) begin
            errors++; $display("FAIL basic_word1 got %h %h want %h %h", bb_in1_dout, bb_in2_dout, s1[1], s2[1]); end
        tick();
        bb_in1_read = 1'b0; bb_in2_read = 1'b0;
        bb_out_r_write = 1'b1; bb_out_r_din = 64'hA;
        #1;
        checks++; if (bb_in1_empty_n !== 1'b0 || bb_in2_empty_n !== 1'b0 || bb_out_r_full_n !== 1'b1) begin
            errors++; $display("FAIL basic_drain got e1=%0b e2=%0b fn=%0b want 0/0/1", bb_in1_empty_n, bb_in2_empty_n, bb_out_r_full_n); end
        tick();
        bb_out_r_din = 64'hB;
        tick();
        bb_out_r_din = 64'hC;
        tick();
        bb_out_r_write = 1'b0; bb_ap_done = 1'b1;
        #1;
        checks++; if (bb_out_r_full_n !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL basic_full got fn=%0b rv=%0b want 0/0", bb_out_r_full_n, result_valid); end
        tick();
        bb_ap_done = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b1 || result_count !== 3'd3 || result_err !== 1'b0) begin
            errors++; $display("FAIL basic_resp got rv=%0b cnt=%0d err=%0b want 1/3/0", result_valid, result_count, result_err); end
        checks++; if (result_data !== exp) begin errors++; $display("FAIL basic_data got %h want %h", result_data, exp); end
        checks++; if (bb_in1_empty_n !== 1'b0 || bb_out_r_full_n !== 1'b0) begin
            errors++; $display("FAIL basic_resp_ports got e1=%0b fn=%0b want 0/0", bb_in1_empty_n, bb_out_r_full_n); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle got rdy=%0b rv=%0b want 1/0", issue_ready, result_valid); end
    endtask

    task automatic test_ap_ready_hold();
        logic [MaxVlen-1:0][63:0] s1, exp;
        int fires;
        fires = 0;
        s1 = '0; s1[0] = 64'h31; s1[1] = 64'h32; s1[2] = 64'h33;
        exp = '0; exp[0] = 64'h100; exp[1] = 64'h101; exp[2] = 64'h102;
        drive_issue(OpCag444ToRgb888, 3'd3, 3'd0, 3'd3, s1, '0);
        #1;
        checks++; if (bb_fire !== 1'b1) begin errors++; $display("FAIL hold_fire got %0b want 1", bb_fire); end
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bb_ap_start !== 1'b1) begin errors++; $display("FAIL hold_start_%0d got 0 want 1", i); end
            if (bb_fire) fires++;
            tick();
        end
        bb_ap_ready = 1'b1;
        #1;
        checks++; if (bb_ap_start !== 1'b1) begin errors++; $display("FAIL hold_start_rdy got 0 want 1"); end
        if (bb_fire) fires++;
        tick();
        bb_ap_ready = 1'b0;
        #1;
        checks++; if (bb_ap_start !== 1'b0) begin errors++; $display("FAIL hold_start_drop got 1 want 0"); end
        checks++; if (bb_in2_empty_n !== 1'b0) begin errors++; $display("FAIL hold_in2_empty got 1 want 0"); end
        checks++; if (fires !== 0) begin errors++; $display("FAIL hold_fire_once got %0d extra want 0", fires); end
        for (int i = 0; i < 3; i++) begin
            bb_in1_read = 1'b1; bb_out_r_write = 1'b1; bb_out_r_din = 64'h100 + 64'(i);
            #1;
            checks++; if (bb_in1_dout !== s1[i]) begin errors++; $display("FAIL hold_rd_%0d got %h want %h", i, bb_in1_dout, s1[i]); end
            tick();
        end
        bb_idle();
        bb_ap_done = 1'b1;
        tick();
        bb_ap_done = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b1 || result_count !== 3'd3 || result_data !== exp) begin
            errors++; $display("FAIL hold_resp got rv=%0b cnt=%0d data=%h want 1/3/%h", result_valid, result_count, result_data, exp); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_overread();
        logic [MaxVlen-1:0][63:0] s1, s2;
        s1 = '0; s1[0] = 64'h40; s1[1] = 64'h41; s1[2] = 64'h42; s1[3] = 64'h43;
        s2 = '0; s2[0] = 64'h50; s2[1] = 64'h51; s2[2] = 64'h52; s2[3] = 64'h53;
        drive_issue(OpNv12ToCag444, 3'd2, 3'd7, 3'd1, s1, s2);
        tick();
        issue_valid = 1'b0;
        bb_ap_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bb_in1_read = 1'b1; bb_in2_read = 1'b1;
            #1;
            if (i < 2) begin
                checks++; if (bb_in1_dout !== s1[i] || bb_in1_empty_n !== 1'b1) begin
                    errors++; $display("FAIL ovr_in1_%0d got %h/%0b want %h/1", i, bb_in1_dout, bb_in1_empty_n, s1[i]); end
            end else begin
                checks++; if (bb_in1_dout !== s1[2] || bb_in1_empty_n !== 1'b0) begin
                    errors++; $display("FAIL ovr_in1_%0d got %h/%0b want %h/0", i, bb_in1_dout, bb_in1_empty_n, s1[2]); end
            end
            checks++; if (bb_in2_dout !== s2[i] || bb_in2_empty_n !== 1'b1) begin
                errors++; $display("FAIL ovr_in2_%0d got %h/%0b want %h/1", i, bb_in2_dout, bb_in2_empty_n, s2[i]); end
            tick();
            bb_ap_ready = 1'b0;
        end
        bb_in1_read = 1'b0; bb_in2_read = 1'b0;
        #1;
        checks++; if (bb_in2_empty_n !== 1'b0) begin errors++; $display("FAIL ovr_clamp got 1 want 0"); end
        bb_out_r_write = 1'b1; bb_out_r_din = 64'h77; bb_ap_done = 1'b1;
        tick();
        bb_idle();
        #1;
        checks++; if (result_valid !== 1'b1 || result_count !== 3'd1 || result_err !== 1'b0) begin
            errors++; $display("FAIL ovr_resp got rv=%0b cnt=%0d err=%0b want 1/1/0", result_valid, result_count, result_err); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [MaxVlen-1:0][63:0] exp;
        exp = '0; exp[0] = 64'hD0; exp[1] = 64'hD1; exp[2] = 64'hD2;
        drive_issue(OpNv12ToCag444, 3'd0, 3'd0, 3'd3, '0, '0);
        tick();
        issue_valid = 1'b0;
        bb_ap_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bb_out_r_write = 1'b1; bb_out_r_din = 64'hD0 + 64'(i);
            #1;
            checks++; if (bb_out_r_full_n !== (i < 3)) begin
                errors++; $display("FAIL ofl_full_%0d got %0b want %0b", i, bb_out_r_full_n, (i < 3)); end
            tick();
            bb_ap_ready = 1'b0;
        end
        bb_out_r_write = 1'b0; bb_ap_done = 1'b1;
        tick();
        bb_ap_done = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b1 || result_err !== 1'b1 || result_count !== 3'd3) begin
            errors++; $display("FAIL ofl_resp got rv=%0b err=%0b cnt=%0d want 1/1/3", result_valid, result_err, result_count); end
        checks++; if (result_data !== exp) begin errors++; $display("FAIL ofl_data got %h want %h", result_data, exp); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic exp_start;
        drive_issue(OpCag444ToRgb888, 3'd1, 3'd1, 3'd1, '0, '0);
        tick();
        issue_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_start = (k < 15);
            #1;
            checks++; if (result_valid !== 1'b0 || bb_ap_start !== exp_start) begin
                errors++; $display("FAIL tmo_run_%0d got rv=%0b st=%0b want 0/%0b", k, result_valid, bb_ap_start, exp_start); end
            tick();
        end
        #1;
        checks++; if (result_valid !== 1'b1 || result_err !== 1'b1 || result_count !== 3'd0) begin
            errors++; $display("FAIL tmo_resp got rv=%0b err=%0b cnt=%0d want 1/1/0", result_valid, result_err, result_count); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        drive_issue(OpNv12ToCag444, 3'd0, 3'd0, 3'd0, '0, '0);
        #1;
        checks++; if (issue_ready !== 1'b1 || bb_fire !== 1'b1) begin
            errors++; $display("FAIL tmo_reissue got rdy=%0b fire=%0b want 1/1", issue_ready, bb_fire); end
        tick();
        issue_valid = 1'b0;
        bb_ap_ready = 1'b1; bb_ap_done = 1'b1;
        #1;
        checks++; if (bb_ap_start !== 1'b1) begin errors++; $display("FAIL tmo_start2 got 0 want 1"); end
        tick();
        bb_idle();
        #1;
        checks++; if (result_valid !== 1'b1 || result_err !== 1'b0 || result_count !== 3'd0) begin
            errors++; $display("FAIL tmo_zero_out got rv=%0b err=%0b cnt=%0d want 1/0/0", result_valid, result_err, result_count); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [MaxVlen-1:0][63:0] s1;
        logic rose;
        rose = 1'b0;
        s1 = '0; s1[0] = 64'h61; s1[1] = 64'h62;
        drive_issue(OpCag444ToRgb888, 3'd2, 3'd2, 3'd2, s1, s1);
        tick();
        issue_valid = 1'b0;
        bb_ap_ready = 1'b1; bb_in1_read = 1'b1;
        tick();
        bb_idle();
        bb_out_r_write = 1'b1; bb_out_r_din = 64'h5;
        tick();
        bb_idle();
        ap_rst_n = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_hs got rdy=%0b rv=%0b want 1/0", issue_ready, result_valid); end
        checks++; if ({bb_ap_start, bb_fire, bb_in1_empty_n, bb_in2_empty_n, bb_out_r_full_n} !== 5'b0) begin
            errors++; $display("FAIL mid_rst_ctrl got %b want 00000",
                {bb_ap_start, bb_fire, bb_in1_empty_n, bb_in2_empty_n, bb_out_r_full_n}); end
        checks++; if (bb_opcode !== OpNone || bb_in1_dout !== '0 || bb_in2_dout !== '0) begin
            errors++; $display("FAIL mid_rst_data got op=%0d d1=%h d2=%h want 0", bb_opcode, bb_in1_dout, bb_in2_dout); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) ap_rst_n = 1'b1;
            if (result_valid) rose = 1'b1;
        end
        checks++; if (rose !== 1'b0 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rst_quiet got rose=%0b rdy=%0b want 0/1", rose, issue_ready); end
    endtask

    initial begin
        ap_rst_n     = 1'b0;
        issue_valid  = 1'b0;
        issue_opcode = OpNone;
        issue_vlen1  = '0;
        issue_vlen2  = '0;
        issue_vlen_out = '0;
        issue_src1   = '0;
        issue_src2   = '0;
        result_ready = 1'b0;
        bb_idle();
        test_reset();
        test_basic();
        test_ap_ready_hold();
        test_overread();
        test_overflow();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
